// File: rtl/config_shift_loader.sv
// rtl/config_shift_loader.sv - serial-to-parallel configuration frame loader with atomic commit
module config_shift_loader #(
    parameter int LEN = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           bit_in_i,
    input  logic           bit_valid_i,
    output logic           bit_ready_o,
    output logic           busy_o,
    output logic [LEN-1:0] cfg_out_o,
    output logic           done_o,
    output logic           cfg_loaded_o
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state_q;
    logic [LEN-1:0]   shreg_q;
    logic [CNT_W-1:0] count_q;
    logic [LEN-1:0]   cfg_q;
    logic             done_q;
    logic             loaded_q;
    logic             busy_q;
    logic             ready_q;

    // Frame FSM: shift accepted bits, then publish the whole frame on a single commit edge.
    // bit_ready/busy are registered alongside the state so they always match it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            count_q  <= '0;
            cfg_q    <= '0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= SHIFT;
                        shreg_q <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start_i) begin
                        // Restart wins over any bit offered on the same edge, including the last one.
                        shreg_q <= '0;
                        count_q <= '0;
                    end else if (bit_valid_i) begin
                        shreg_q <= {shreg_q[LEN-2:0], bit_in_i};
                        count_q <= count_q + 1'b1;
                        if (count_q == LAST_IDX) begin
                            state_q <= COMMIT;
                            ready_q <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    cfg_q    <= shreg_q;
                    done_q   <= 1'b1;
                    loaded_q <= 1'b1;
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bit_ready_o  = ready_q;
    assign busy_o       = busy_q;
    assign cfg_out_o    = cfg_q;
    assign done_o       = done_q;
    assign cfg_loaded_o = loaded_q;

endmodule

// File: tb/tb_config_shift_loader.sv
// tb/tb_config_shift_loader.sv - directed self-checking bench for config_shift_loader
module tb_config_shift_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       busy;
    logic [7:0] cfg_out;
    logic       done;
    logic       cfg_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    config_shift_loader #(.LEN(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .bit_in_i     (bit_in),
        .bit_valid_i  (bit_valid),
        .bit_ready_o  (bit_ready),
        .busy_o       (busy),
        .cfg_out_o    (cfg_out),
        .done_o       (done),
        .cfg_loaded_o (cfg_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
    endtask

    // Drive n bits of v MSB-first; with gap=1 a bit_valid=0 cycle follows each bit.
    task automatic shift_bits(input logic [7:0] v, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = v[7-i];
            tick();
            if (gap) begin
                bit_valid = 1'b0;
                bit_in    = 1'b0;
                tick();
            end
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            start     = 1'($urandom_range(0, 1));
            bit_in    = 1'($urandom_range(0, 1));
            bit_valid = 1'($urandom_range(0, 1));
            tick();
            n_checks++; if (cfg_out !== 8'h00) begin n_fail++; $display("FAIL reset_cfg: got %h want 00", cfg_out); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
            n_checks++; if (cfg_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_loaded: got %b want 0", cfg_loaded); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
            n_checks++; if (bit_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bit_ready); end
        end
        rst = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        tick();
    endtask

    task automatic test_frame_a0();
        logic [7:0] pat;
        pat = 8'hA0;
        done_seen = 0;
        pulse_start();
        n_checks++; if (busy !== 1'b1 || bit_ready !== 1'b1) begin n_fail++; $display("FAIL a0_shift_entry: busy=%b ready=%b want 1 1", busy, bit_ready); end
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            bit_in    = pat[7-i];
            tick();
            n_checks++; if (done !== 1'b0 || cfg_out !== 8'h00) begin n_fail++; $display("FAIL a0_during_shift%0d: done=%b cfg=%h want 0 00", i, done, cfg_out); end
        end
        bit_valid = 1'b0;
        n_checks++; if (bit_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL a0_commit_state: ready=%b busy=%b want 0 1", bit_ready, busy); end
        tick();
        n_checks++; if (cfg_out !== 8'hA0) begin n_fail++; $display("FAIL a0_cfg: got %h want a0", cfg_out); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL a0_done: got %b want 1", done); end
        n_checks++; if (cfg_loaded !== 1'b1) begin n_fail++; $display("FAIL a0_loaded: got %b want 1", cfg_loaded); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a0_busy_after: got %b want 0", busy); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL a0_done_drop: got %b want 0", done); end
        n_checks++; if (done_seen != 1) begin n_fail++; $display("FAIL a0_done_count: got %0d want 1", done_seen); end
        n_checks++; if ({cfg_out[7], cfg_out[5], cfg_out[3], cfg_out[1]} !== 4'b1100) begin n_fail++; $display("FAIL a0_stride_odd: got %b want 1100", {cfg_out[7], cfg_out[5], cfg_out[3], cfg_out[1]}); end
        n_checks++; if ({cfg_out[6], cfg_out[4], cfg_out[2], cfg_out[0]} !== 4'b0000) begin n_fail++; $display("FAIL a0_stride_even: got %b want 0000", {cfg_out[6], cfg_out[4], cfg_out[2], cfg_out[0]}); end
    endtask

    task automatic test_gapped_55();
        logic [7:0] pat;
        pat = 8'h55;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            bit_in    = pat[7-i];
            tick();
            n_checks++; if (cfg_out !== 8'hA0 || done !== 1'b0) begin n_fail++; $display("FAIL g55_hold_bit%0d: cfg=%h done=%b want a0 0", i, cfg_out, done); end
            if (i < 7) begin
                n_checks++; if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL g55_ready_bit%0d: got %b want 1", i, bit_ready); end
            end
            bit_valid = 1'b0;
            bit_in    = 1'b0;
            tick();
            if (i < 7) begin
                n_checks++; if (bit_ready !== 1'b1 || cfg_out !== 8'hA0) begin n_fail++; $display("FAIL g55_gap%0d: ready=%b cfg=%h want 1 a0", i, bit_ready, cfg_out); end
            end
        end
        n_checks++; if (cfg_out !== 8'h55 || done !== 1'b1) begin n_fail++; $display("FAIL g55_commit: cfg=%h done=%b want 55 1", cfg_out, done); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL g55_done_drop: got %b want 0", done); end
    endtask

    task automatic test_abort_restart();
        done_seen = 0;
        pulse_start();
        shift_bits(8'hFF, 4, 1'b0);
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        n_checks++; if (cfg_out !== 8'h55 || busy !== 1'b1 || bit_ready !== 1'b1) begin n_fail++; $display("FAIL abort_hold: cfg=%h busy=%b ready=%b want 55 1 1", cfg_out, busy, bit_ready); end
        shift_bits(8'hAA, 8, 1'b0);
        tick();
        n_checks++; if (cfg_out !== 8'hAA) begin n_fail++; $display("FAIL abort_cfg: got %h want aa", cfg_out); end
        tick();
        n_checks++; if (done_seen != 1) begin n_fail++; $display("FAIL abort_done_count: got %0d want 1", done_seen); end
    endtask

    task automatic test_start_on_last_bit();
        done_seen = 0;
        pulse_start();
        shift_bits(8'hFF, 7, 1'b0);
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        n_checks++; if (busy !== 1'b1 || bit_ready !== 1'b1) begin n_fail++; $display("FAIL last_restart_state: busy=%b ready=%b want 1 1", busy, bit_ready); end
        tick();
        tick();
        n_checks++; if (done_seen != 0 || cfg_out !== 8'hAA) begin n_fail++; $display("FAIL last_discard: dones=%0d cfg=%h want 0 aa", done_seen, cfg_out); end
        shift_bits(8'h3C, 8, 1'b0);
        tick();
        n_checks++; if (cfg_out !== 8'h3C || done !== 1'b1) begin n_fail++; $display("FAIL last_reload: cfg=%h done=%b want 3c 1", cfg_out, done); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        done_seen = 0;
        pulse_start();
        shift_bits(8'hF8, 5, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (cfg_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_cfg: got %h want 00", cfg_out); end
        n_checks++; if (cfg_loaded !== 1'b0) begin n_fail++; $display("FAIL rstmid_loaded: got %b want 0", cfg_loaded); end
        n_checks++; if (busy !== 1'b0 || bit_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: busy=%b ready=%b want 0 0", busy, bit_ready); end
        shift_bits(8'hFF, 4, 1'b0);
        n_checks++; if (done_seen != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: dones=%0d busy=%b want 0 0", done_seen, busy); end
    endtask

    task automatic test_idle_ignore();
        pulse_start();
        shift_bits(8'hC3, 8, 1'b0);
        tick();
        tick();
        n_checks++; if (cfg_out !== 8'hC3) begin n_fail++; $display("FAIL idle_setup: got %h want c3", cfg_out); end
        for (int c = 0; c < 20; c++) begin
            bit_valid = 1'b1;
            bit_in    = c[0];
            tick();
            n_checks++;
            if (cfg_out !== 8'hC3 || done !== 1'b0 || busy !== 1'b0 || bit_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: cfg=%h done=%b busy=%b ready=%b want c3 0 0 0", c, cfg_out, done, busy, bit_ready);
            end
        end
        bit_valid = 1'b0; bit_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        test_reset();
        test_frame_a0();
        test_gapped_55();
        test_abort_restart();
        test_start_on_last_bit();
        test_reset_mid_frame();
        test_idle_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
